// File: rtl/ddr_rx_pkg.sv
// Shared types and default sizes for the DDR serial word receiver.
package ddr_rx_pkg;

    typedef enum logic [0:0] {
        HUNT,
        SHIFT
    } rx_state_t;

    localparam int unsigned DDR_WORD_W   = 8;
    localparam int unsigned DDR_RX_DEPTH = 4;

endpackage

// File: rtl/ddr_rx_fifo.sv
// First-word-fall-through FIFO used as the output buffer of ddr_word_rx.
// A push while full is only accepted when a pop frees a slot on the same edge.
module ddr_rx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    // Accept/ignore decisions for this edge.
    always_comb begin
        do_pop  = pop && (count != '0);
        do_push = push && ((count != CNT_FULL) || do_pop);
        full    = (count == CNT_FULL);
        empty   = (count == '0);
        rd_data = mem[rd_ptr];
    end

    // Storage, pointers and occupancy; storage is cleared so the head reads zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ddr_word_rx.sv
// Double-data-rate serial word receiver: captures one bit per clock edge, assembles
// MSB-first words aligned by sync, and hands them out through a small FWFT buffer.
// WORD_W must be even and >= 4; DEPTH must be a power of two and >= 2.
module ddr_word_rx
    import ddr_rx_pkg::*;
#(
    parameter int unsigned WORD_W = DDR_WORD_W,
    parameter int unsigned DEPTH  = DDR_RX_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din,
    input  logic              sync,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              align_err,
    output logic              overflow
);

    localparam int unsigned PAIRS = WORD_W / 2;
    localparam int unsigned CNT_W = $clog2(PAIRS) + 1;

    rx_state_t         state_q, state_d;
    logic [CNT_W-1:0]  pair_cnt_q, pair_cnt_d;
    logic [CNT_W-1:0]  cnt_inc;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [WORD_W-1:0] word_next;
    logic [WORD_W-1:0] word_load;
    logic              align_err_q, align_err_d;
    logic              overflow_q, overflow_d;
    logic              neg_bit;
    logic [1:0]        pair;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;

    // Falling-edge capture of the earlier bit of each pair.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_bit <= 1'b0;
        end else begin
            neg_bit <= din;
        end
    end

    // Pair assembly: earlier (falling-edge) bit lands on the MSB side.
    always_comb begin
        pair      = {neg_bit, din};
        word_next = {shreg_q[WORD_W-3:0], pair};
        word_load = {{(WORD_W - 2){1'b0}}, pair};
        cnt_inc   = pair_cnt_q + CNT_W'(1);
    end

    // Framing FSM: hunt for sync, then shift pairs and emit a word every PAIRS edges.
    always_comb begin
        state_d     = state_q;
        pair_cnt_d  = pair_cnt_q;
        shreg_d     = shreg_q;
        align_err_d = 1'b0;
        push        = 1'b0;
        case (state_q)
            HUNT: begin
                if (sync) begin
                    shreg_d    = word_load;
                    pair_cnt_d = CNT_W'(1);
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (sync) begin
                    // A sync at a word boundary is just a redundant realignment.
                    shreg_d     = word_load;
                    pair_cnt_d  = CNT_W'(1);
                    align_err_d = (pair_cnt_q != '0);
                end else if (cnt_inc == CNT_W'(PAIRS)) begin
                    shreg_d    = word_next;
                    pair_cnt_d = '0;
                    push       = 1'b1;
                end else begin
                    shreg_d    = word_next;
                    pair_cnt_d = cnt_inc;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    // Handshake and sticky drop detection.
    always_comb begin
        pop        = out_ready && !fifo_empty;
        overflow_d = overflow_q || (push && fifo_full && !pop);
        out_valid  = !fifo_empty;
        align_err  = align_err_q;
        overflow   = overflow_q;
    end

    // Rising-edge state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            pair_cnt_q  <= '0;
            shreg_q     <= '0;
            align_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pair_cnt_q  <= pair_cnt_d;
            shreg_q     <= shreg_d;
            align_err_q <= align_err_d;
            overflow_q  <= overflow_d;
        end
    end

    ddr_rx_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (word_next),
        .pop       (pop),
        .rd_data   (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_ddr_word_rx.sv
// Randomised scoreboard bench for ddr_word_rx with a queue-based reference model.
module tb_ddr_word_rx;

    localparam int unsigned W     = 8;
    localparam int unsigned D     = 4;
    localparam int unsigned PAIRS = W / 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         din = 1'b0;
    logic         sync = 1'b0;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         align_err;
    logic         overflow;

    int vectors = 0;
    int miscompares = 0;
    int rdy_mode = 0;   // 0: ready low, 1: ready high, 2: random per pair

    // Reference model state
    logic [W-1:0] exp_q[$];
    int           mdl_cnt = 0;
    bit           hunting = 1'b1;
    int           npairs = 0;
    int unsigned  acc = 0;
    logic         mdl_neg = 1'b0;
    logic         exp_align = 1'b0;
    logic         exp_ovf = 1'b0;

    // Observation counters
    int           align_seen = 0;
    int           popped_n = 0;
    logic [W-1:0] last_pop = '0;

    ddr_word_rx #(
        .WORD_W (W),
        .DEPTH  (D)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .sync      (sync),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .align_err (align_err),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: earlier bit of each pair is whatever din held at the falling edge.
    always @(negedge clk) begin
        if (rst_n) mdl_neg = din;
    end

    // Model: per rising edge, framing with plain arithmetic and a bounded word count.
    always @(posedge clk) begin
        int unsigned p;
        bit done;
        if (rst_n) begin
            p = {30'd0, mdl_neg, din};
            done = 1'b0;
            exp_align = 1'b0;
            if (out_ready && mdl_cnt > 0) mdl_cnt--;
            if (hunting) begin
                if (sync) begin
                    acc = p; npairs = 1; hunting = 1'b0;
                end
            end else if (sync) begin
                exp_align = (npairs != 0);
                acc = p; npairs = 1;
            end else begin
                acc = (acc * 4 + p) % (1 << W);
                npairs++;
                if (npairs == PAIRS) begin
                    done = 1'b1; npairs = 0;
                end
            end
            if (done) begin
                if (mdl_cnt < D) begin
                    mdl_cnt++;
                    exp_q.push_back(acc[W-1:0]);
                end else begin
                    exp_ovf = 1'b1;
                end
            end
        end
    end

    // Monitor: compares DUT outputs against the model midway between rising edges.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, mdl_cnt != 0});
            chk("align_err", {31'd0, align_err}, {31'd0, exp_align});
            chk("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
            if (align_err) align_seen++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    chk("out_data", 32'(out_data), 32'(exp_q[0]));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        popped_n++;
                        last_pop = out_data;
                    end
                end
            end
        end
    end

    task automatic send_pair(input logic b1, input logic b0, input logic s);
        @(posedge clk); #1;
        din  = b1;
        sync = s;
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        @(negedge clk); #1;
        din = b0;
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic s);
        for (int i = 0; i < PAIRS; i++) begin
            send_pair(w[W-1-2*i], w[W-2-2*i], s && (i == 0));
        end
    endtask

    task automatic idle(input int n, input logic s);
        for (int i = 0; i < n; i++) begin
            send_pair(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), s);
        end
    endtask

    // Asynchronous reset mid-cycle; outputs must clear without waiting for a clock.
    task automatic do_reset();
        @(negedge clk); #2;
        rst_n = 1'b0;
        sync  = 1'b0;
        exp_q.delete();
        mdl_cnt = 0; hunting = 1'b1; npairs = 0; acc = 0;
        mdl_neg = 1'b0; exp_align = 1'b0; exp_ovf = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_align_err", {31'd0, align_err}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #1 rst_n = 1'b0;

        // Basic word
        do_reset();
        rdy_mode = 1; popped_n = 0;
        send_word(8'hA5, 1'b1);
        @(posedge clk); #1;
        chk("basic_valid", {31'd0, out_valid}, 32'd1);
        chk("basic_data", 32'(out_data), 32'hA5);
        @(posedge clk); #1;
        chk("basic_one_cycle", {31'd0, out_valid}, 32'd0);

        // Back-to-back without a second sync
        do_reset();
        rdy_mode = 1; popped_n = 0; align_seen = 0;
        send_word(8'h3C, 1'b1);
        send_word(8'hC3, 1'b0);
        idle(2, 1'b0);
        chk("b2b_count", 32'(popped_n), 32'd2);
        chk("b2b_last", 32'(last_pop), 32'hC3);
        chk("b2b_no_align", 32'(align_seen), 32'd0);

        // Misalignment
        do_reset();
        rdy_mode = 1; popped_n = 0; align_seen = 0;
        send_pair(1'b1, 1'b1, 1'b1);
        send_pair(1'b0, 1'b1, 1'b0);
        send_word(8'h5A, 1'b1);
        idle(2, 1'b0);
        chk("mis_align_pulses", 32'(align_seen), 32'd1);
        chk("mis_count", 32'(popped_n), 32'd1);
        chk("mis_word", 32'(last_pop), 32'h5A);

        // Backpressure and overflow
        do_reset();
        rdy_mode = 0;
        send_word(8'h11, 1'b1);
        send_word(8'h22, 1'b0);
        send_word(8'h33, 1'b0);
        send_word(8'h44, 1'b0);
        send_word(8'h55, 1'b0);
        idle(1, 1'b1);
        chk("bp_overflow", {31'd0, overflow}, 32'd1);
        popped_n = 0;
        rdy_mode = 1;
        idle(6, 1'b1);
        chk("bp_drained", 32'(popped_n), 32'd4);
        chk("bp_last", 32'(last_pop), 32'h44);

        // Full buffer with a pop on the completing edge
        do_reset();
        rdy_mode = 0;
        send_word(8'h81, 1'b1);
        send_word(8'h42, 1'b0);
        send_word(8'h24, 1'b0);
        send_word(8'h18, 1'b0);
        send_pair(1'b1, 1'b1, 1'b0);
        send_pair(1'b1, 1'b0, 1'b0);
        send_pair(1'b0, 1'b1, 1'b0);
        rdy_mode = 1;
        send_pair(1'b1, 1'b1, 1'b0);   // completes 0xE7 while popping
        popped_n = 0;
        idle(6, 1'b1);
        chk("fp_no_overflow", {31'd0, overflow}, 32'd0);
        chk("fp_count", 32'(popped_n), 32'd4);
        chk("fp_last", 32'(last_pop), 32'hE7);

        // Reset mid-word with a buffered word, then ignore pairs until sync
        do_reset();
        rdy_mode = 0;
        send_word(8'h96, 1'b1);
        send_pair(1'b1, 1'b1, 1'b0);
        send_pair(1'b0, 1'b1, 1'b0);
        do_reset();
        rdy_mode = 1; popped_n = 0;
        idle(8, 1'b0);
        chk("rst_hunt", 32'(popped_n), 32'd0);
        send_word(8'h69, 1'b1);
        idle(2, 1'b0);
        chk("rst_resume", 32'(last_pop), 32'h69);

        // Randomised traffic
        rdy_mode = 2;
        for (int it = 0; it < 300; it++) begin
            int r;
            r = $urandom_range(0, 39);
            if (r < 24) begin
                send_word(W'($urandom), 1'($urandom_range(0, 2) == 0));
            end else if (r < 34) begin
                for (int k = 0; k < $urandom_range(1, 3); k++) begin
                    send_pair(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 5) == 0));
                end
            end else if (r < 39) begin
                rdy_mode = $urandom_range(0, 2);
            end else begin
                do_reset();
            end
        end
        rdy_mode = 1;
        idle(8, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ddr_word_rx.md
# ddr_word_rx

Double-data-rate serial word receiver. Samples a 1-bit serial line on both edges of one clock: the falling-edge stage captures the earlier bit of each pair, the rising-edge stage captures the later bit. It assembles MSB-first words aligned by a frame-sync strobe and delivers them through a small buffer with a valid/ready handshake. It is the capture end of the dual-edge launch links in the design: the far end launches one bit per clock edge, and this block brings the data back into the rising-edge domain.

## Interface
Parameters:
- `WORD_W`, default 8. Word width. Must be even and ≥ 4.
- `DEPTH`, default 4. Output buffer depth in words. Must be a power of two and ≥ 2.

Ports:
- `clk`  in  1  Single clock. Both edges are used for capture; all other logic runs on the rising edge.
- `rst_n`  in  1  Asynchronous active-low reset. Clears every flop, including the falling-edge stage.
- `din`  in  1  Serial data, one bit per clock edge.
- `sync`  in  1  Sampled at the rising edge. High marks the current pair as bits [W-1:W-2] of a new word.
- `out_data`  out  WORD_W  Head word of the buffer.
- `out_valid`  out  1  The buffer is non-empty.
- `out_ready`  in  1  The consumer accepts `out_data` on a rising edge where `out_valid && out_ready`.
- `align_err`  out  1  One-cycle pulse: `sync` arrived while a word was partially assembled.
- `overflow`  out  1  Sticky flag: a completed word was dropped because the buffer was full. Cleared only by reset.

## Operation
Capture:
- The falling-edge flop `neg_bit` samples `din`.
- At each rising edge, pair = {`neg_bit`, `din`}. `neg_bit` is the earlier bit and goes first (MSB side).
- The shift register takes 2 bits per rising edge.

State machine (rising edge):
- HUNT: pairs are discarded until `sync`=1. The pair arriving with `sync` loads the shift register, and `pair_cnt` becomes 1. Next state is SHIFT.
- SHIFT with `sync`=0: shift in the pair and increment `pair_cnt`.
  - When `pair_cnt` reaches WORD_W/2, the word is complete and is pushed to the buffer in the same edge.
  - `pair_cnt` then wraps to 0 and the block stays in SHIFT. Back-to-back words need no further `sync`.
- SHIFT with `sync`=1 and `pair_cnt`=0 (word boundary): the pair starts a new word normally. No error is raised.
- SHIFT with `sync`=1 and `pair_cnt`≠0: the partial word is discarded, the pair starts a new word, and `align_err` pulses for one cycle.

Buffer:
- FIFO, first-word-fall-through.
- Push while full with no pop in the same edge: the word is dropped and `overflow` is set.
- Push and pop in the same edge while full: both take effect, and the word is kept.
- Pop while empty: ignored.

Reset values:
- `out_valid`=0, `out_data`=0, `align_err`=0, `overflow`=0.
- State = HUNT, `pair_cnt`=0, `neg_bit`=0, buffer empty.

Reset mid-word or mid-buffer: all partial and buffered words are lost. After reset the block hunts for `sync` again.

## Timing
- `sync` high at rising edge t0 carries pair 0. Pair j arrives at t0+j.
- The word completes at edge t0+WORD_W/2−1 and `out_valid` is high immediately after that edge. For WORD_W=8 this is after t0+3.
- Pop takes effect at the rising edge. The next word, if present, is on `out_data` right after that edge.
- `align_err` is registered and high for exactly the cycle after the offending edge.
- `din` must meet setup/hold around both edges. The block provides no metastability protection on `din` or `sync`.

## Structure
- Package `ddr_rx_pkg` holds:
  - the state enum `rx_state_t` {HUNT, SHIFT};
  - the default constants `DDR_WORD_W`=8 and `DDR_RX_DEPTH`=4.
- Sub-module `ddr_rx_fifo` holds the storage, pointers, count and full/empty logic, parameterised by width and depth.
- The top level keeps the falling-edge flop, the pair assembly, the FSM and the sticky flags.

## Test plan
- **Basic word:** `sync` with the first pair, then pairs (1,0),(1,0),(0,1),(0,1), with `out_ready`=1. Required: `out_data`=0xA5 and `out_valid` high for one cycle after the 4th pair edge.
- **Back-to-back:** 0x3C then 0xC3 with no second `sync`. Required: two words in order, `align_err` never asserted.
- **Misalignment:** `sync`, 2 pairs, then `sync` again followed by 0x5A. Required: one `align_err` pulse, only 0x5A delivered.
- **Backpressure:** `out_ready`=0 while 5 words are sent. Required: the first 4 are held and `overflow`=1 after the 5th. Then `out_ready`=1 drains exactly the first 4, in order.
- **Full with simultaneous pop:** buffer full, `out_ready`=1 on the edge a new word completes. Required: no overflow, and the new word is delivered last.
- **Reset mid-word:** `rst_n` asserted after 2 pairs. Required: all outputs at their reset values asynchronously, and pairs after release are ignored until the next `sync`.
